// File: rtl/sfla40_16x8_bw16.sv
// sfla40_16x8_bw16: synchronous ternary CAM, Words x Bits entries.
//
// Each entry holds data, a per-bit care mask (1 = care) and a valid bit.
// One command is executed per enabled clock edge with precedence
// FLUSH > WR > RD > CMP. All outputs are registered.
//
// Optional feature: define TCAM_MULTIHIT_EN to add the MHIT output
// (set when two or more HITLINE bits are set after a compare).
//
// Ports:
//   CK       clock, rising edge
//   RST      synchronous active-high reset (clears arrays and outputs)
//   CS       chip select; 0 = no operation, outputs hold
//   FLUSH    invalidate all entries of enabled banks
//   VBE      valid-bit enable for WR / RD
//   DCS      data-cell enable for WR / RD
//   WR/RD/CMP write, read and compare strobes
//   DI       write data / search key
//   MSKB     write: entry care mask; compare: search mask (1 = compare bit)
//   VBI      valid bit written when VBE=1
//   A        entry address for WR/RD
//   CBE      active-low bank enables; CBE[b]=1 blocks WR/CMP/FLUSH in bank b
//   DO/VBO   registered read data / read valid bit
//   HIT      registered OR of HITLINE
//   HITLINE  registered per-entry match vector
//   MHIT     (TCAM_MULTIHIT_EN only) registered multi-hit flag
module sfla40_16x8_bw16 #(
  parameter int unsigned Bits        = 8,
  parameter int unsigned Words       = 16,
  parameter int unsigned AddressSize = 4,
  parameter int unsigned BankSize    = 1
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   CS,
  input  logic                   FLUSH,
  input  logic                   VBE,
  input  logic                   DCS,
  input  logic                   WR,
  input  logic                   RD,
  input  logic                   CMP,
  input  logic [Bits-1:0]        DI,
  input  logic [Bits-1:0]        MSKB,
  input  logic                   VBI,
  input  logic [AddressSize-1:0] A,
  input  logic [BankSize-1:0]    CBE,
  output logic [Bits-1:0]        DO,
  output logic                   VBO,
  output logic                   HIT,
  output logic [Words-1:0]       HITLINE
`ifdef TCAM_MULTIHIT_EN
  ,
  output logic                   MHIT
`endif
);

  localparam int unsigned WordsPerBank = Words / BankSize;

  logic [Bits-1:0]  data_q [Words];
  logic [Bits-1:0]  mask_q [Words];
  logic [Words-1:0] valid_q;
  logic [Bits-1:0]  do_q;
  logic             vbo_q;
  logic             hit_q;
  logic [Words-1:0] hitline_q;

  logic [Words-1:0] word_en;
  logic [Words-1:0] wr_sel;
  logic [Words-1:0] match;
  logic [Words-1:0] cmp_hitline;
  logic [Words-1:0] flush_hitline;
  logic [Bits-1:0]  rd_data;
  logic             rd_valid;
  logic             addr_ok;
  logic             do_flush;
  logic             do_wr;
  logic             do_rd;
  logic             do_cmp;

  // Per-entry bank enable derived from the contiguous bank grouping.
  for (genvar g = 0; g < Words; g++) begin : g_bank
    localparam int unsigned Bank = g / WordsPerBank;
    assign word_en[g] = ~CBE[Bank];
  end

  assign do_flush = CS & FLUSH;
  assign do_wr    = CS & ~FLUSH & WR;
  assign do_rd    = CS & ~FLUSH & ~WR & RD;
  assign do_cmp   = CS & ~FLUSH & ~WR & ~RD & CMP;
  assign addr_ok  = 32'(A) < Words;

  always_comb begin
    wr_sel   = '0;
    match    = '0;
    rd_data  = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < Words; i++) begin
      wr_sel[i] = (A == AddressSize'(i)) & word_en[i];
      // A bit mismatches only when both the entry and the search care about it.
      match[i]  = valid_q[i] & ((mask_q[i] & MSKB & (DI ^ data_q[i])) == '0);
      // Out-of-range addresses fall through to zero.
      if (A == AddressSize'(i)) begin
        rd_data  = data_q[i];
        rd_valid = valid_q[i];
      end
    end
  end

  // Entries in blocked banks keep their previous HITLINE bits.
  assign cmp_hitline   = (match & word_en) | (hitline_q & ~word_en);
  assign flush_hitline = hitline_q & ~word_en;

`ifdef TCAM_MULTIHIT_EN
  logic mhit_q;

  function automatic logic multi_hit(input logic [Words-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < Words; i++) begin
      if (v[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return multi;
  endfunction

  always_ff @(posedge CK) begin
    if (RST) begin
      mhit_q <= 1'b0;
    end else if (do_flush) begin
      mhit_q <= multi_hit(flush_hitline);
    end else if (do_cmp) begin
      mhit_q <= multi_hit(cmp_hitline);
    end
  end

  assign MHIT = mhit_q;
`endif

  always_ff @(posedge CK) begin
    if (RST) begin
      for (int i = 0; i < Words; i++) begin
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      valid_q   <= '0;
      do_q      <= '0;
      vbo_q     <= 1'b0;
      hit_q     <= 1'b0;
      hitline_q <= '0;
    end else begin
      if (do_flush) begin
        valid_q   <= valid_q & ~word_en;
        hitline_q <= flush_hitline;
        hit_q     <= |flush_hitline;
      end
      if (do_wr && addr_ok) begin
        for (int i = 0; i < Words; i++) begin
          if (wr_sel[i]) begin
            if (DCS) begin
              data_q[i] <= DI;
              mask_q[i] <= MSKB;
            end
            if (VBE) valid_q[i] <= VBI;
          end
        end
      end
      if (do_rd) begin
        do_q  <= DCS ? rd_data : '0;
        vbo_q <= VBE ? rd_valid : 1'b0;
      end
      if (do_cmp) begin
        hitline_q <= cmp_hitline;
        hit_q     <= |cmp_hitline;
      end
    end
  end

  assign DO      = do_q;
  assign VBO     = vbo_q;
  assign HIT     = hit_q;
  assign HITLINE = hitline_q;

endmodule

// File: tb/tb_sfla40_16x8_bw16.sv
// Self-checking bench for sfla40_16x8_bw16: directed scenarios with literal
// expectations, then randomized commands checked every cycle against a
// behavioural CAM model.
module tb_sfla40_16x8_bw16;

  logic        CK = 1'b0;
  logic        RST, CS, FLUSH, VBE, DCS, WR, RD, CMP, VBI;
  logic [7:0]  DI, MSKB, DO;
  logic [3:0]  A;
  logic [0:0]  CBE;
  logic        VBO, HIT;
  logic [15:0] HITLINE;
  logic        mhit;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Behavioural model state
  logic [7:0]  m_data [16];
  logic [7:0]  m_mask [16];
  logic        m_valid [16];
  logic [7:0]  m_do;
  logic        m_vbo, m_hit, m_mhit;
  logic [15:0] m_hitline;

  sfla40_16x8_bw16 dut (
    .CK(CK), .RST(RST), .CS(CS), .FLUSH(FLUSH), .VBE(VBE), .DCS(DCS),
    .WR(WR), .RD(RD), .CMP(CMP), .DI(DI), .MSKB(MSKB), .VBI(VBI), .A(A),
    .CBE(CBE), .DO(DO), .VBO(VBO), .HIT(HIT), .HITLINE(HITLINE)
`ifdef TCAM_MULTIHIT_EN
    , .MHIT(mhit)
`endif
  );

`ifndef TCAM_MULTIHIT_EN
  assign mhit = 1'b0;
`endif

  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one enabled command per edge, decided from the spec's rules.
  task automatic model_update();
    int n;
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        m_data[i] = 0; m_mask[i] = 0; m_valid[i] = 0;
      end
      m_do = 0; m_vbo = 0; m_hit = 0; m_hitline = 0; m_mhit = 0;
    end else if (CS) begin
      if (FLUSH) begin
        if (!CBE[0]) begin
          for (int i = 0; i < 16; i++) m_valid[i] = 0;
          m_hitline = 0; m_hit = 0; m_mhit = 0;
        end
      end else if (WR) begin
        if (!CBE[0]) begin
          if (DCS) begin m_data[A] = DI; m_mask[A] = MSKB; end
          if (VBE) m_valid[A] = VBI;
        end
      end else if (RD) begin
        m_do  = DCS ? m_data[A] : 8'h00;
        m_vbo = VBE ? m_valid[A] : 1'b0;
      end else if (CMP) begin
        if (!CBE[0]) begin
          n = 0;
          for (int i = 0; i < 16; i++) begin
            bit ok;
            ok = m_valid[i];
            for (int j = 0; j < 8; j++)
              if (m_mask[i][j] && MSKB[j] && (DI[j] != m_data[i][j])) ok = 0;
            m_hitline[i] = ok;
            if (ok) n++;
          end
          m_hit  = (n != 0);
          m_mhit = (n >= 2);
        end
      end
    end
  endtask

  task automatic idle();
    RST = 0; CS = 1; FLUSH = 0; VBE = 0; DCS = 0; WR = 0; RD = 0; CMP = 0;
    VBI = 0; DI = 0; MSKB = 0; A = 0; CBE = 0;
  endtask

  task automatic step();
    @(posedge CK);
    model_update();
    @(negedge CK);
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    idle(); WR = 1; A = a; DI = d; MSKB = m; VBE = 1; DCS = 1; VBI = 1; step();
  endtask

  task automatic do_rd(input logic [3:0] a);
    idle(); RD = 1; A = a; VBE = 1; DCS = 1; step();
  endtask

  task automatic do_cmp(input logic [7:0] d, input logic [7:0] m);
    idle(); CMP = 1; DI = d; MSKB = m; step();
  endtask

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge CK) begin
    if (cmp_en) begin
      #1;
      chk("do_model", {24'h0, DO}, {24'h0, m_do});
      chk("vbo_model", {31'h0, VBO}, {31'h0, m_vbo});
      chk("hit_model", {31'h0, HIT}, {31'h0, m_hit});
      chk("hitline_model", {16'h0, HITLINE}, {16'h0, m_hitline});
`ifdef TCAM_MULTIHIT_EN
      chk("mhit_model", {31'h0, mhit}, {31'h0, m_mhit});
`endif
    end
  end

  initial begin
    idle();
    @(negedge CK);
    RST = 1; step();
    cmp_en = 1;
    chk("rst_do", {24'h0, DO}, 32'h0);
    chk("rst_vbo", {31'h0, VBO}, 32'h0);
    chk("rst_hitline", {16'h0, HITLINE}, 32'h0);
    do_cmp(8'h00, 8'h00);
    chk("cmp_all_invalid", {31'h0, HIT}, 32'h0);

    do_wr(4'd3, 8'hA0, 8'hF0);
    do_rd(4'd3);
    chk("rd3_do", {24'h0, DO}, 32'hA0);
    chk("rd3_vbo", {31'h0, VBO}, 32'h1);
    do_cmp(8'hA5, 8'hF0);
    chk("cmp_a5_hit", {31'h0, HIT}, 32'h1);
    chk("cmp_a5_hitline", {16'h0, HITLINE}, 32'h0008);
    do_cmp(8'hB0, 8'hF0);
    chk("cmp_b0_hit", {31'h0, HIT}, 32'h0);

    do_wr(4'd9, 8'hA7, 8'h0F);
    do_cmp(8'hA7, 8'hFF);
    chk("cmp_a7_hitline", {16'h0, HITLINE}, 32'h0208);
`ifdef TCAM_MULTIHIT_EN
    chk("cmp_a7_mhit", {31'h0, mhit}, 32'h1);
`endif

    idle(); FLUSH = 1; step();
    chk("flush_hitline", {16'h0, HITLINE}, 32'h0);
    do_cmp(8'hA0, 8'hF0);
    chk("flush_cmp_hit", {31'h0, HIT}, 32'h0);
    do_rd(4'd3);
    chk("flush_rd_do", {24'h0, DO}, 32'hA0);
    chk("flush_rd_vbo", {31'h0, VBO}, 32'h0);

    // WR with FLUSH on the same edge: flush only.
    idle(); WR = 1; FLUSH = 1; A = 5; DI = 8'h55; MSKB = 8'hFF; VBE = 1; DCS = 1; VBI = 1; step();
    do_rd(4'd5);
    chk("wr_flush_do", {24'h0, DO}, 32'h00);
    chk("wr_flush_vbo", {31'h0, VBO}, 32'h0);
    // CS=0 write ignored; outputs hold.
    idle(); CS = 0; WR = 1; A = 6; DI = 8'h66; VBE = 1; DCS = 1; VBI = 1; step();
    chk("cs0_hold_do", {24'h0, DO}, 32'h00);
    do_rd(4'd6);
    chk("cs0_wr_do", {24'h0, DO}, 32'h00);
    // Bank disabled write ignored.
    idle(); CBE = 1; WR = 1; A = 7; DI = 8'h77; VBE = 1; DCS = 1; VBI = 1; step();
    do_rd(4'd7);
    chk("cbe_wr_do", {24'h0, DO}, 32'h00);
    chk("cbe_wr_vbo", {31'h0, VBO}, 32'h0);

    // Randomized traffic; keys often drawn from stored data to produce hits.
    for (int c = 0; c < 3000; c++) begin
      int k;
      idle();
      RST   = ($urandom_range(0, 199) == 0);
      CS    = ($urandom_range(0, 7) != 0);
      FLUSH = ($urandom_range(0, 39) == 0);
      WR    = ($urandom_range(0, 2) == 0);
      RD    = ($urandom_range(0, 2) == 0);
      CMP   = ($urandom_range(0, 1) == 0);
      VBE   = ($urandom_range(0, 5) != 0);
      DCS   = ($urandom_range(0, 5) != 0);
      VBI   = ($urandom_range(0, 3) != 0);
      CBE   = 1'($urandom_range(0, 9) == 0);
      A     = 4'($urandom_range(0, 15));
      k     = $urandom_range(0, 15);
      DI    = ($urandom_range(0, 1) == 0) ? (m_data[k] ^ 8'(1 << $urandom_range(0, 7)))
                                          : 8'($urandom);
      if ($urandom_range(0, 2) == 0) DI = m_data[k];
      MSKB  = 8'($urandom);
      step();
    end

    cmp_en = 0;
    @(negedge CK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
